// File: rtl/sna_pkg.sv
// Shared definitions for the slave-side network adapter: flit layout, flit types
// and the request-flow state encoding.
package sna_pkg;

   localparam int FLIT_W  = 34;
   localparam int TYPE_HI = 33;
   localparam int TYPE_LO = 32;
   localparam int PAY_HI  = 31;
   localparam int PAY_LO  = 0;
   localparam int STRB_HI = 3;
   localparam int STRB_LO = 0;
   localparam int SRC_LO  = 4;

   localparam logic [1:0] FLIT_HEAD_RD = 2'b00;
   localparam logic [1:0] FLIT_HEAD_WR = 2'b01;
   localparam logic [1:0] FLIT_BODY    = 2'b10;
   localparam logic [1:0] FLIT_TAIL    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BODY,
      ST_WAIT_TAIL_RD,
      ST_WAIT_TAIL_WR,
      ST_AXI_RD,
      ST_AXI_WR
   } state_e;

endpackage

// File: rtl/sna_req_axi_drv.sv
// AXI4-Lite request-channel driver: raises AR or AW+W valids on start, drops each
// on its own handshake and flags the cycle in which the whole request completes.
module sna_req_axi_drv (
   input  logic clk,
   input  logic rst_n,
   input  logic start_rd,
   input  logic start_wr,
   input  logic arready,
   input  logic awready,
   input  logic wready,
   output logic arvalid,
   output logic awvalid,
   output logic wvalid,
   output logic done
);

   logic wr_busy;
   logic aw_ok;
   logic w_ok;

   // A write finishes in the cycle where every channel still open is handshaking.
   assign wr_busy = awvalid || wvalid;
   assign aw_ok   = !awvalid || awready;
   assign w_ok    = !wvalid || wready;
   assign done    = (arvalid && arready) || (wr_busy && aw_ok && w_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arvalid <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
      end else begin
         if (start_rd)
            arvalid <= 1'b1;
         else if (arvalid && arready)
            arvalid <= 1'b0;

         if (start_wr)
            awvalid <= 1'b1;
         else if (awvalid && awready)
            awvalid <= 1'b0;

         if (start_wr)
            wvalid <= 1'b1;
         else if (wvalid && wready)
            wvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/sna_request.sv
// Request-flow network adapter: assembles NoC request packets and replays them as
// AXI4-Lite reads/writes. Optional assembly watchdog: define SNA_REQ_TIMEOUT_EN.
module sna_request
   import sna_pkg::*;
#(
   parameter int NUM_VC      = 8,
   parameter int SRC_ID_W    = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [FLIT_W-1:0]         noc_data,
   input  logic                      is_valid,
   input  logic [$clog2(NUM_VC)-1:0] noc_vc,
   output logic [NUM_VC-1:0]         is_on_off,
   output logic [31:0]               araddr,
   output logic                      arvalid,
   input  logic                      arready,
   output logic [31:0]               awaddr,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [31:0]               wdata,
   output logic [3:0]                wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   output logic [SRC_ID_W-1:0]       req_src_id,
   output logic [$clog2(NUM_VC)-1:0] req_vc,
   output logic                      req_done,
   output logic                      proto_err
);

   localparam int VC_W = $clog2(NUM_VC);

   state_e              state;
   logic [VC_W-1:0]     lock_vc;
   logic [SRC_ID_W-1:0] src_lat;
   logic [1:0]          ftype;
   logic [31:0]         payload;
   logic [NUM_VC-1:0]   vc_onehot;
   logic                accept;
   logic                start_rd;
   logic                start_wr;
   logic                axi_done;
   logic                tmo_hit;

   assign ftype     = noc_data[TYPE_HI:TYPE_LO];
   assign payload   = noc_data[PAY_HI:PAY_LO];
   assign vc_onehot = NUM_VC'(1) << noc_vc;
   assign accept    = is_valid && is_on_off[noc_vc];
   assign start_rd  = accept && (state == ST_WAIT_TAIL_RD) && (ftype == FLIT_TAIL);
   assign start_wr  = accept && (state == ST_WAIT_TAIL_WR) && (ftype == FLIT_TAIL);

`ifdef SNA_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             in_asm;

   assign in_asm  = state inside {ST_WAIT_BODY, ST_WAIT_TAIL_RD, ST_WAIT_TAIL_WR};
   assign tmo_hit = in_asm && !accept && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (!in_asm || accept)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + CNT_W'(1);
   end
`else
   logic unused_cfg;

   assign tmo_hit    = 1'b0;
   assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

   sna_req_axi_drv u_axi_drv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_rd (start_rd),
      .start_wr (start_wr),
      .arready  (arready),
      .awready  (awready),
      .wready   (wready),
      .arvalid  (arvalid),
      .awvalid  (awvalid),
      .wvalid   (wvalid),
      .done     (axi_done)
   );

   // NOTE: every register here uses <= so all decisions see pre-edge values; a
   // blocking write would leak the next state into later tests in the same block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         is_on_off  <= '1;
         lock_vc    <= '0;
         src_lat    <= '0;
         araddr     <= '0;
         awaddr     <= '0;
         wdata      <= '0;
         wstrb      <= '0;
         req_src_id <= '0;
         req_vc     <= '0;
         req_done   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         // Flits on a closed VC are dropped and reported.
         proto_err <= is_valid && !accept;
         req_done  <= axi_done;

         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  unique case (ftype)
                     FLIT_HEAD_RD: begin
                        araddr    <= payload;
                        lock_vc   <= noc_vc;
                        is_on_off <= vc_onehot;
                        state     <= ST_WAIT_TAIL_RD;
                     end
                     FLIT_HEAD_WR: begin
                        awaddr    <= payload;
                        lock_vc   <= noc_vc;
                        is_on_off <= vc_onehot;
                        state     <= ST_WAIT_BODY;
                     end
                     default: proto_err <= 1'b1;
                  endcase
               end
            end
            ST_WAIT_BODY: begin
               if (accept) begin
                  if (ftype == FLIT_BODY) begin
                     wdata <= payload;
                     state <= ST_WAIT_TAIL_WR;
                  end else begin
                     proto_err <= 1'b1;
                     is_on_off <= '1;
                     state     <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_TAIL_RD: begin
               if (accept) begin
                  if (ftype == FLIT_TAIL) begin
                     src_lat   <= noc_data[SRC_LO +: SRC_ID_W];
                     is_on_off <= '0;
                     state     <= ST_AXI_RD;
                  end else begin
                     proto_err <= 1'b1;
                     is_on_off <= '1;
                     state     <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_TAIL_WR: begin
               if (accept) begin
                  if (ftype == FLIT_TAIL) begin
                     wstrb     <= noc_data[STRB_HI:STRB_LO];
                     src_lat   <= noc_data[SRC_LO +: SRC_ID_W];
                     is_on_off <= '0;
                     state     <= ST_AXI_WR;
                  end else begin
                     proto_err <= 1'b1;
                     is_on_off <= '1;
                     state     <= ST_IDLE;
                  end
               end
            end
            ST_AXI_RD, ST_AXI_WR: begin
               if (axi_done) begin
                  req_src_id <= src_lat;
                  req_vc     <= lock_vc;
                  is_on_off  <= '1;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               is_on_off <= '1;
               state     <= ST_IDLE;
            end
         endcase

         if (tmo_hit) begin
            proto_err <= 1'b1;
            is_on_off <= '1;
            state     <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_sna_request.sv
// Scoreboard bench for sna_request: directed scenarios plus random packets with
// random AXI readys, checked against a packet-level reference model.
module tb_sna_request;
   import sna_pkg::*;

   localparam int NUM_VC   = 8;
   localparam int SRC_ID_W = 8;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [7:0]  src;
      logic [2:0]  vc;
   } txn_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [FLIT_W-1:0]   noc_data = '0;
   logic                is_valid = 1'b0;
   logic [2:0]          noc_vc = '0;
   logic [NUM_VC-1:0]   is_on_off;
   logic [31:0]         araddr, awaddr, wdata;
   logic [3:0]          wstrb;
   logic                arvalid, awvalid, wvalid;
   logic                arready = 1'b0, awready = 1'b0, wready = 1'b0;
   logic [SRC_ID_W-1:0] req_src_id;
   logic [2:0]          req_vc;
   logic                req_done, proto_err;

   int   checks = 0;
   int   failures = 0;
   int   exp_proto = 0;
   int   proto_seen = 0;
   int   exp_done = 0;
   int   done_seen = 0;
   bit   rand_ready = 1'b0;
   txn_t exp_q[$];

   always #5 clk = ~clk;

   sna_request #(
      .NUM_VC      (NUM_VC),
      .SRC_ID_W    (SRC_ID_W),
      .TIMEOUT_CYC (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .noc_data   (noc_data),
      .is_valid   (is_valid),
      .noc_vc     (noc_vc),
      .is_on_off  (is_on_off),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .awaddr     (awaddr),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .req_src_id (req_src_id),
      .req_vc     (req_vc),
      .req_done   (req_done),
      .proto_err  (proto_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one flit for one cycle; optionally waits (bounded) for the VC to open.
   task automatic send(input logic [1:0] ft, input logic [31:0] pay, input int vc, input bit wait_on);
      int n = 0;
      while (wait_on && !is_on_off[vc] && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 300) check("on_off_wait", 64'(is_on_off[vc]), 1);
      noc_data = {ft, pay};
      noc_vc   = 3'(vc);
      is_valid = 1'b1;
      @(posedge clk); #1;
      is_valid = 1'b0;
   endtask

   function automatic logic [31:0] tail_pay(input logic [7:0] src, input logic [3:0] strb);
      return {20'd0, src, strb};
   endfunction

   task automatic expect_txn(input bit wr, input int vc, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input logic [7:0] src);
      txn_t t;
      t = '{wr, addr, data, strb, src, 3'(vc)};
      exp_q.push_back(t);
      exp_done++;
   endtask

   task automatic packet(input bit wr, input int vc, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input logic [7:0] src);
      expect_txn(wr, vc, addr, data, strb, src);
      send(wr ? FLIT_HEAD_WR : FLIT_HEAD_RD, addr, vc, 1'b1);
      if (wr) send(FLIT_BODY, data, vc, 1'b1);
      send(FLIT_TAIL, tail_pay(src, strb), vc, 1'b1);
   endtask

   // Monitor: captures AXI handshakes, pops the scoreboard on each req_done.
   bit          ar_seen, aw_seen, w_seen, ar_stall, aw_stall, w_stall;
   logic [31:0] ar_addr, aw_addr, w_data, prev_ar, prev_aw, prev_w;
   logic [3:0]  w_strb;
   txn_t        mon_t;

   always @(negedge clk) begin
      if (!rst_n) begin
         {ar_seen, aw_seen, w_seen, ar_stall, aw_stall, w_stall} = '0;
      end else begin
         if (ar_stall) check("ar_hold", {arvalid, araddr}, {1'b1, prev_ar});
         if (aw_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_aw});
         if (w_stall)  check("w_hold", {wvalid, wdata}, {1'b1, prev_w});
         ar_stall = arvalid && !arready;  prev_ar = araddr;
         aw_stall = awvalid && !awready;  prev_aw = awaddr;
         w_stall  = wvalid && !wready;    prev_w  = wdata;
         if (arvalid && arready) begin ar_seen = 1'b1; ar_addr = araddr; end
         if (awvalid && awready) begin aw_seen = 1'b1; aw_addr = awaddr; end
         if (wvalid && wready) begin w_seen = 1'b1; w_data = wdata; w_strb = wstrb; end
         if (proto_err) proto_seen++;
         if (req_done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
               check("done_unexpected", 64'(req_done), 0);
            end else begin
               mon_t = exp_q.pop_front();
               if (mon_t.wr) begin
                  check("wr_hs_seen", {ar_seen, aw_seen, w_seen}, 3'b011);
                  check("wr_awaddr", aw_addr, mon_t.addr);
                  check("wr_wdata", w_data, mon_t.data);
                  check("wr_wstrb", w_strb, mon_t.strb);
               end else begin
                  check("rd_hs_seen", {ar_seen, aw_seen, w_seen}, 3'b100);
                  check("rd_araddr", ar_addr, mon_t.addr);
               end
               check("done_src_id", req_src_id, mon_t.src);
               check("done_vc", req_vc, mon_t.vc);
            end
            {ar_seen, aw_seen, w_seen} = '0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #2;
         if (rand_ready) begin
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_on_off", is_on_off, 8'hFF);
      check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
      check("rst_outs", {araddr, awaddr}, 64'd0);
      check("rst_misc", {wdata, wstrb, req_src_id, req_vc, req_done, proto_err}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_on_off", is_on_off, 8'hFF);

      // Read on VC 3
      arready = 1'b1;
      expect_txn(1'b0, 3, 32'h0000_1000, 32'd0, 4'd0, 8'h2A);
      send(FLIT_HEAD_RD, 32'h0000_1000, 3, 1'b1);
      check("rd_on_off_asm", is_on_off, 8'h08);
      send(FLIT_TAIL, tail_pay(8'h2A, 4'h0), 3, 1'b1);
      check("rd_arvalid_lat", {arvalid, araddr}, {1'b1, 32'h0000_1000});
      check("rd_on_off_axi", is_on_off, 8'h00);
      @(posedge clk); #1;
      check("rd_done_pulse", {req_done, arvalid}, 2'b10);
      check("rd_req_id", {req_src_id, req_vc}, {8'h2A, 3'd3});
      check("rd_idle_on_off", is_on_off, 8'hFF);
      arready = 1'b0;

      // Write with awready delayed, wready immediate
      wready = 1'b1;
      expect_txn(1'b1, 2, 32'h20, 32'hDEAD_BEEF, 4'hF, 8'h11);
      send(FLIT_HEAD_WR, 32'h20, 2, 1'b1);
      send(FLIT_BODY, 32'hDEAD_BEEF, 2, 1'b1);
      send(FLIT_TAIL, tail_pay(8'h11, 4'hF), 2, 1'b1);
      check("wr_valids_rise", {awvalid, wvalid}, 2'b11);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         check("wr_aw_hold", {awvalid, wvalid, req_done}, 3'b100);
         if (k == 3) awready = 1'b1;
      end
      @(posedge clk); #1;
      check("wr_done_both", {awvalid, wvalid, req_done}, 3'b001);
      awready = 1'b0;

      // Stray flit on another VC while assembling on VC 1
      awready = 1'b1;
      expect_txn(1'b1, 1, 32'h44, 32'h1234_5678, 4'h3, 8'h05);
      send(FLIT_HEAD_WR, 32'h44, 1, 1'b1);
      send(FLIT_BODY, 32'h0BAD_0BAD, 5, 1'b0);
      exp_proto++;
      check("vc_stray_err", {proto_err, is_on_off}, {1'b1, 8'h02});
      send(FLIT_BODY, 32'h1234_5678, 1, 1'b1);
      send(FLIT_TAIL, tail_pay(8'h05, 4'h3), 1, 1'b1);

      // HEAD_WR followed by TAIL, then a BODY in IDLE
      send(FLIT_HEAD_WR, 32'h80, 0, 1'b1);
      send(FLIT_TAIL, tail_pay(8'h01, 4'h1), 0, 1'b1);
      exp_proto++;
      check("bad_seq_err", {proto_err, is_on_off}, {1'b1, 8'hFF});
      repeat (3) @(posedge clk);
      #1;
      check("bad_seq_no_axi", {arvalid, awvalid, wvalid}, 3'b000);
      send(FLIT_BODY, 32'h99, 4, 1'b1);
      exp_proto++;
      check("idle_body_err", {proto_err, is_on_off}, {1'b1, 8'hFF});

`ifdef SNA_REQ_TIMEOUT_EN
      send(FLIT_HEAD_RD, 32'h300, 6, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check("tmo_pending", {proto_err, is_on_off}, {1'b0, 8'h40});
      @(posedge clk); #1;
      check("tmo_not_yet", 64'(proto_err), 0);
      @(posedge clk); #1;
      exp_proto++;
      check("tmo_fire", {proto_err, is_on_off}, {1'b1, 8'hFF});
`else
      arready = 1'b1;
      expect_txn(1'b0, 6, 32'h300, 32'd0, 4'd0, 8'h66);
      send(FLIT_HEAD_RD, 32'h300, 6, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("no_tmo_wait", {proto_err, is_on_off}, {1'b0, 8'h40});
      send(FLIT_TAIL, tail_pay(8'h66, 4'h0), 6, 1'b1);
`endif

      // Random packets with random readys
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int          vc;
         int          kind;
         logic [31:0] a, d;
         vc   = $urandom_range(0, NUM_VC - 1);
         kind = $urandom_range(0, 9);
         a    = $urandom;
         d    = $urandom;
         if (kind < 7) begin
            packet(1'($urandom_range(0, 1)), vc, a, d, 4'($urandom), 8'($urandom));
         end else begin
            exp_proto++;
            if (kind == 7) begin
               send(FLIT_HEAD_WR, a, vc, 1'b1);
               send(FLIT_TAIL, d, vc, 1'b1);
            end else if (kind == 8) begin
               send(FLIT_HEAD_RD, a, vc, 1'b1);
               send(FLIT_BODY, d, vc, 1'b1);
            end else begin
               send(FLIT_BODY, d, vc, 1'b1);
            end
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;

      // Asynchronous reset while a write is outstanding
      send(FLIT_HEAD_WR, 32'h700, 7, 1'b1);
      send(FLIT_BODY, 32'h7777, 7, 1'b1);
      send(FLIT_TAIL, tail_pay(8'h77, 4'hF), 7, 1'b1);
      check("arst_pre", {awvalid, wvalid}, 2'b11);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valids_drop", {awvalid, wvalid, is_on_off}, {2'b00, 8'hFF});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_release", {awvalid, wvalid, arvalid, is_on_off}, {3'b000, 8'hFF});

      repeat (2) @(posedge clk);
      #1;
      check("proto_count", proto_seen, exp_proto);
      check("done_count", done_seen, exp_done);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sna_request.md
Name: sna_request

Overview:
- Slave-side network adapter, request flow: receives 34-bit NoC request packets and replays them as AXI4-Lite master transactions (AR, or AW+W) toward the attached slave.
- Counterpart of the response-flow adapter. Exports the requester's source ID and VC so the response path can address its reply.
- Flow control toward the router is per-VC on/off.

Parameters:
- NUM_VC, 8, number of virtual channels; width of the on/off mask.
- SRC_ID_W, 8, source-node ID width carried in the tail flit (must be ≤ 28).
- TIMEOUT_CYC, 255, watchdog limit in cycles, used only with SNA_REQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- noc_data  in  34  incoming flit.
- is_valid  in  1  flit valid this cycle.
- noc_vc  in  $clog2(NUM_VC)  VC of the incoming flit.
- is_on_off  out  NUM_VC  per-VC accept mask (1 = may send).
- araddr  out  32  AXI read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- awaddr  out  32  AXI write address.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  32  AXI write data.
- wstrb  out  4  AXI write strobe.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- req_src_id  out  SRC_ID_W  source ID of the last accepted packet, for the response path.
- req_vc  out  $clog2(NUM_VC)  VC of the last accepted packet.
- req_done  out  1  one-cycle pulse when the AXI request phase completes.
- proto_err  out  1  one-cycle pulse on a protocol violation or dropped flit.

Behaviour:
- Flit format by type field [33:32]:
  - 00 HEAD_RD: [31:0] = address.
  - 01 HEAD_WR: [31:0] = address.
  - 10 BODY: [31:0] = wdata.
  - 11 TAIL: [3:0] = wstrb, [4+SRC_ID_W-1:4] = source ID.
- Read packet = HEAD_RD, TAIL. Write packet = HEAD_WR, BODY, TAIL.
- A flit is accepted when is_valid = 1 and is_on_off[noc_vc] = 1 in the same cycle.
- Reset values:
  - is_on_off = all ones.
  - All AXI valids = 0.
  - araddr, awaddr, wdata, wstrb, req_src_id, req_vc = 0.
  - req_done = 0, proto_err = 0.
  - State = IDLE.
- State IDLE, is_on_off = all ones:
  - HEAD_RD: latch address and VC, go to WAIT_TAIL_RD.
  - HEAD_WR: latch address and VC, go to WAIT_BODY.
  - BODY or TAIL in IDLE: drop it, pulse proto_err.
- Assembly states (WAIT_BODY, WAIT_TAIL_RD, WAIT_TAIL_WR):
  - is_on_off = one-hot of the locked VC.
  - A flit on any other VC cannot be accepted; if is_valid is still seen there, pulse proto_err and ignore the flit.
- WAIT_BODY:
  - BODY: latch wdata, go to WAIT_TAIL_WR.
  - Any other type: pulse proto_err, return to IDLE, discard the packet.
- WAIT_TAIL_RD:
  - TAIL: latch source ID, go to AXI_RD.
  - Any other type: proto_err, return to IDLE.
- WAIT_TAIL_WR:
  - TAIL: latch wstrb and source ID, go to AXI_WR.
  - Any other type: proto_err, return to IDLE.
- AXI_RD, is_on_off = 0:
  - arvalid = 1 from the cycle after tail acceptance.
  - araddr is stable until arvalid && arready.
  - On handshake: arvalid = 0, req_done pulses, req_src_id and req_vc update, return to IDLE.
- AXI_WR, is_on_off = 0:
  - awvalid and wvalid both rise together.
  - Each channel drops independently on its own handshake.
  - Same-cycle handshake on both channels is legal.
  - Once both channels are complete: req_done pulses, req_src_id and req_vc update, return to IDLE.
- Valid rules: valids never deassert before their handshake; ready may be asserted before valid.
- Latency, tail accepted to first valid: 1 cycle. Idle recovery: IDLE is entered in the handshake cycle, so the next header can be accepted the following cycle.
- Reset mid-operation: valids drop asynchronously, the partial packet is lost, is_on_off returns to all ones.

Optional Feature:
- SNA_REQ_TIMEOUT_EN defined:
  - A counter runs in the assembly states and reloads on each accepted flit.
  - Reaching TIMEOUT_CYC: return to IDLE, pulse proto_err.
  - The counter does not run in the AXI states.
- Not defined: no counter; the block waits indefinitely.

Decomposition:
- Shared package sna_pkg:
  - Flit type localparams FLIT_HEAD_RD, FLIT_HEAD_WR, FLIT_BODY, FLIT_TAIL.
  - FLIT_W = 34.
  - Bit-field index constants.
  - State encoding enum.
- Sub-module sna_req_axi_drv: holds the AW/W/AR valid/handshake-tracking logic and produces done. The FSM and flit decode stay in the top.

Test Plan:
- Read: HEAD_RD 0x0000_1000 on VC 3, then TAIL with src 0x2A, arready = 1 → arvalid next cycle with araddr 0x1000; req_done pulse; req_src_id = 0x2A; req_vc = 3; is_on_off = 0x08 during assembly.
- Write with skewed readys: HEAD_WR 0x20, BODY 0xDEADBEEF, TAIL wstrb 0xF; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle; awvalid holds 4 cycles; req_done fires only after both handshakes.
- Wrong VC: during WAIT_BODY on VC 1, drive is_valid on VC 5 → proto_err pulse; state unchanged; following BODY on VC 1 completes normally.
- Bad sequence: HEAD_WR followed by TAIL → proto_err; no AXI valid ever asserts; block back in IDLE with is_on_off = 0xFF.
- Async reset: assert rst_n low while awvalid = 1 → awvalid = 0 immediately; after release is_on_off = 0xFF.
- With SNA_REQ_TIMEOUT_EN and TIMEOUT_CYC = 10: HEAD_RD then silence → proto_err pulses 10 cycles after the header; IDLE restored.
